// File: rtl/avalon_mult_pkg.sv
// rtl/avalon_mult_pkg.sv - shared constants and types for the Avalon-MM shift-add multiplier
//
// Purpose: register map, CTRL/STATUS bit positions, engine FSM states and the
//          default ID value used by avalon_mult_slave and mult_shift_add.
// Ports:   none (package).
// Config:  AVALON_MULT_IRQ_EN is consumed by avalon_mult_slave, not here.
package avalon_mult_pkg;

  // Word addresses of the register file
  localparam int unsigned REG_OPA    = 0;
  localparam int unsigned REG_OPB    = 1;
  localparam int unsigned REG_CTRL   = 2;
  localparam int unsigned REG_STATUS = 3;
  localparam int unsigned REG_RES_LO = 4;
  localparam int unsigned REG_RES_HI = 5;
  localparam int unsigned REG_CYCLES = 6;
  localparam int unsigned REG_ID     = 7;

  // CTRL bits
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS bits
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  localparam logic [31:0] DEFAULT_ID = 32'hACCE_0001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/avalon_mult_slave_if.sv
// rtl/avalon_mult_slave_if.sv - Avalon-MM register bus between CPU interconnect and the multiplier
//
// Purpose: bundles the Avalon-MM slave signals of avalon_mult_slave.
// Ports:   avs_address/avs_read/avs_write/avs_writedata driven by the master;
//          avs_readdata/avs_waitrequest driven by the slave.
// Config:  none.
interface avalon_mult_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) ();
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [DATA_W-1:0] avs_writedata;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_mult_slave_mult_shift_add.sv
// rtl/avalon_mult_slave_mult_shift_add.sv - iterative unsigned shift-add multiplier engine
//
// Purpose: computes opa * opb over DATA_W cycles, one multiplier bit per cycle.
// Ports:   clk, reset (sync, active-high); start (sampled only in IDLE);
//          opa/opb operands; busy (engine in RUN); done (one-cycle pulse in the
//          last RUN cycle); product (final value, valid while done=1).
// Config:  none.
module mult_shift_add
  import avalon_mult_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     opa,
  input  logic [DATA_W-1:0]     opb,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  state_e                state_q, state_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{DATA_W{1'b0}}, opa};
          mplier_d = opb;
          acc_d    = '0;
          cnt_d    = CNT_W'(DATA_W);
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // Last step: the wrapper captures the final sum in this same cycle so
        // done/result become visible together with busy dropping.
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    product = acc_d;
  end

  assign busy = (state_q == RUN);

endmodule

// File: rtl/avalon_mult_slave.sv
// rtl/avalon_mult_slave.sv - Avalon-MM register wrapper around the shift-add multiplier
//
// Purpose: register file (OPA, OPB, CTRL, STATUS, RES_LO, RES_HI, CYCLES, ID),
//          start/error policy and read stalling of result reads while busy.
// Ports:   clk, reset (sync, active-high); avs (avalon_mult_slave_if.slave);
//          irq (only with AVALON_MULT_IRQ_EN) = registered done & irq_en.
// Config:  `define AVALON_MULT_IRQ_EN to add the irq output.
module avalon_mult_slave
  import avalon_mult_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 3,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(DEFAULT_ID)
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_mult_slave_if.slave   avs
`ifdef AVALON_MULT_IRQ_EN
  ,
  output logic                 irq
`endif
);
  logic [DATA_W-1:0]   opa_q, opa_d, opb_q, opb_d, cycles_q, cycles_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                irq_en_q, irq_en_d, done_q, done_d, err_q, err_d;

  logic                start_req, eng_busy, eng_done;
  logic [2*DATA_W-1:0] eng_product;
  logic [DATA_W-1:0]   rdata;
  int unsigned         reg_idx;
  logic                wr, rd;

  mult_shift_add #(.DATA_W(DATA_W)) u_engine (
    .clk     (clk),
    .reset   (reset),
    .start   (start_req),
    .opa     (opa_q),
    .opb     (opb_q),
    .busy    (eng_busy),
    .done    (eng_done),
    .product (eng_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      cycles_q <= '0;
      res_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cycles_q <= cycles_d;
      res_q    <= res_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign reg_idx = 32'(avs.avs_address);
  assign wr      = avs.avs_write;
  // A simultaneous read+write is treated as a write only.
  assign rd      = avs.avs_read && !avs.avs_write;

  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    cycles_d  = cycles_q;
    res_d     = res_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    start_req = 1'b0;
    if (wr) begin
      case (reg_idx)
        REG_OPA: if (eng_busy) err_d = 1'b1; else opa_d = avs.avs_writedata;
        REG_OPB: if (eng_busy) err_d = 1'b1; else opb_d = avs.avs_writedata;
        REG_CTRL: begin
          irq_en_d = avs.avs_writedata[CTRL_IRQ_EN];
          if (avs.avs_writedata[CTRL_START]) begin
            if (eng_busy) err_d = 1'b1;
            else          start_req = 1'b1;
          end
        end
        REG_STATUS: begin
          if (avs.avs_writedata[ST_DONE]) done_d = 1'b0;
          if (avs.avs_writedata[ST_ERR])  err_d  = 1'b0;
        end
        default: ;
      endcase
    end
    // Completion overrides a done-clear arriving in the same cycle.
    if (eng_done) begin
      res_d    = eng_product;
      done_d   = 1'b1;
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (!reset) begin
      case (reg_idx)
        REG_OPA:    rdata = opa_q;
        REG_OPB:    rdata = opb_q;
        REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en_q;
        REG_STATUS: begin
          rdata[ST_BUSY] = eng_busy;
          rdata[ST_DONE] = done_q;
          rdata[ST_ERR]  = err_q;
        end
        REG_RES_LO: rdata = res_q[DATA_W-1:0];
        REG_RES_HI: rdata = res_q[2*DATA_W-1:DATA_W];
        REG_CYCLES: rdata = cycles_q;
        REG_ID:     rdata = ID_VALUE;
        default:    rdata = '0;
      endcase
    end
  end

  assign avs.avs_readdata    = rdata;
  // Gated by reset so an aborted operation releases the bus in the reset cycle.
  assign avs.avs_waitrequest = !reset && rd && eng_busy &&
                               (reg_idx == REG_RES_LO || reg_idx == REG_RES_HI);

`ifdef AVALON_MULT_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = done_q & irq_en_q;
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_avalon_mult_slave.sv
// tb/tb_avalon_mult_slave.sv - directed self-checking bench for avalon_mult_slave
module tb_avalon_mult_slave;
  import avalon_mult_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;
  logic [31:0] data;

  always #5 clk = ~clk;

  avalon_mult_slave_if #(.DATA_W(32), .ADDR_W(3)) bus ();

`ifdef AVALON_MULT_IRQ_EN
  logic irq;
  avalon_mult_slave dut (.clk(clk), .reset(reset), .avs(bus), .irq(irq));
`else
  avalon_mult_slave dut (.clk(clk), .reset(reset), .avs(bus));
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    bus.avs_address   = 3'(a);
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int unsigned a, input logic [31:0] exp);
    bus.avs_address = 3'(a);
    bus.avs_read    = 1'b1;
    #1;
    check(tag, bus.avs_readdata, exp);
    bus.avs_read    = 1'b0;
    tick();
  endtask

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst_wait", bus.avs_waitrequest, 0);
    for (int a = 0; a < 7; a++) rd_chk($sformatf("rst_reg%0d", a), a, 32'h0);
    rd_chk("id", REG_ID, 32'hACCE_0001);

    // 7 * 6: busy for 32 cycles, done at T+33
    wr(REG_OPA, 7);
    wr(REG_OPB, 6);
    wr(REG_CTRL, 32'h1);                       // now in cycle T+1
    rd_chk("t1_busy_first", REG_STATUS, 32'h1);
    repeat (30) tick();                        // cycle T+32
    rd_chk("t1_busy_last", REG_STATUS, 32'h1);
    rd_chk("t1_done", REG_STATUS, 32'h2);      // cycle T+33
    rd_chk("t1_res_lo", REG_RES_LO, 42);
    rd_chk("t1_res_hi", REG_RES_HI, 0);
    rd_chk("t1_cycles", REG_CYCLES, 1);

    // Max operands, stalled RES_HI read
    wr(REG_OPA, 32'hFFFF_FFFF);
    wr(REG_OPB, 32'hFFFF_FFFF);
    wr(REG_CTRL, 32'h1);
    bus.avs_address = 3'(REG_RES_HI);
    bus.avs_read    = 1'b1;
    n = 0;
    #1;
    while (bus.avs_waitrequest && n < 100) begin
      tick();
      n++;
    end
    check("t2_wait_cycles", n, 32);
    check("t2_res_hi", bus.avs_readdata, 32'hFFFF_FFFE);
    bus.avs_read = 1'b0;
    tick();
    rd_chk("t2_res_lo", REG_RES_LO, 32'h0000_0001);

    // Writes during RUN are ignored and set err
    wr(REG_OPA, 32'hFFFF_FFFF);
    wr(REG_CTRL, 32'h1);
    wr(REG_OPA, 5);
    wr(REG_CTRL, 32'h1);
    repeat (35) tick();
    rd_chk("t3_status_err", REG_STATUS, 32'h6);
    rd_chk("t3_opa_kept", REG_OPA, 32'hFFFF_FFFF);
    rd_chk("t3_res_lo", REG_RES_LO, 32'h0000_0001);
    rd_chk("t3_res_hi", REG_RES_HI, 32'hFFFF_FFFE);
    wr(REG_STATUS, 32'h4);
    rd_chk("t3_err_clr", REG_STATUS, 32'h2);

    // Done-clear in the exact completion cycle loses to completion
    wr(REG_OPA, 7);
    wr(REG_OPB, 6);
    wr(REG_CTRL, 32'h1);                       // cycle T+1
    repeat (31) tick();                        // cycle T+32
    wr(REG_STATUS, 32'h2);
    rd_chk("t5_done_wins", REG_STATUS, 32'h2);
    wr(REG_STATUS, 32'h2);
    rd_chk("t5_done_clr", REG_STATUS, 32'h0);
    rd_chk("t5_cycles", REG_CYCLES, 4);

    // Reset while a RES_LO read is stalled
    wr(REG_CTRL, 32'h1);                       // cycle T+1
    repeat (9) tick();                         // cycle T+10
    bus.avs_address = 3'(REG_RES_LO);
    bus.avs_read    = 1'b1;
    #1;
    check("t4_wait_before", bus.avs_waitrequest, 1);
    reset = 1'b1;
    #1;
    check("t4_wait_in_reset", bus.avs_waitrequest, 0);
    tick();
    reset = 1'b0;
    #1;
    check("t4_wait_after", bus.avs_waitrequest, 0);
    check("t4_res_lo_read", bus.avs_readdata, 0);
    bus.avs_read = 1'b0;
    tick();
    rd_chk("t4_status", REG_STATUS, 32'h0);
    rd_chk("t4_cycles", REG_CYCLES, 0);
    rd_chk("t4_opa", REG_OPA, 0);

`ifdef AVALON_MULT_IRQ_EN
    // irq = registered done & irq_en
    wr(REG_OPA, 3);
    wr(REG_OPB, 4);
    wr(REG_CTRL, 32'h3);                       // cycle T+1
    rd_chk("irq_ctrl", REG_CTRL, 32'h2);
    repeat (31) tick();                        // cycle T+33
    check("irq_at_done", irq, 0);
    tick();                                    // cycle T+34
    check("irq_set", irq, 1);
    rd_chk("irq_res", REG_RES_LO, 12);
    wr(REG_STATUS, 32'h2);
    check("irq_hold", irq, 1);
    tick();
    check("irq_clr", irq, 0);
    wr(REG_CTRL, 32'h1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (irq) n++;
      tick();
    end
    check("irq_disabled", n, 0);
    rd_chk("irq_dis_done", REG_STATUS, 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
